// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory read-modify-write sequencer:
// access-size encodings, FSM state type and the alignment check.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCESS  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4
    } dmem_state_t;

    // A half must sit on an even byte, a word on a 4-byte boundary;
    // the reserved size code 2'b11 is always rejected.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational lane logic: extracts and extends the addressed byte/half
// of a read word for loads, and splices store data into a read word for
// sub-word stores (little-endian lane numbering).
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [15:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merge_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed byte and half lanes from the read word.
    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        if (i_addr_lo[1]) begin
            w_half = i_rdata[31:16];
        end else begin
            w_half = i_rdata[15:0];
        end
    end

    // Sign- or zero-extend the selected lane; word loads pass through.
    always_comb begin
        case (i_size)
            SZ_BYTE: o_load_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: o_load_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            default: o_load_data = i_rdata;
        endcase
    end

    // Replace the addressed lane of the read word with the store data.
    always_comb begin
        o_merge_data = i_rdata;
        case (i_size)
            SZ_BYTE: begin
                case (i_addr_lo)
                    2'd0:    o_merge_data[7:0]   = i_wdata[7:0];
                    2'd1:    o_merge_data[15:8]  = i_wdata[7:0];
                    2'd2:    o_merge_data[23:16] = i_wdata[7:0];
                    2'd3:    o_merge_data[31:24] = i_wdata[7:0];
                    default: o_merge_data        = i_rdata;
                endcase
            end
            SZ_HALF: begin
                if (i_addr_lo[1]) begin
                    o_merge_data[31:16] = i_wdata;
                end else begin
                    o_merge_data[15:0]  = i_wdata;
                end
            end
            default: o_merge_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/dmem_rmw_ctrl.sv
// MEM-stage sequencer in front of a single-port, synchronous-read,
// write-first word memory. Byte/half/word loads and stores are turned
// into word accesses; sub-word stores use read-modify-write. Misaligned
// requests are answered with an error and never touch the memory.
module dmem_rmw_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,   // only 32 is supported
    parameter int ADDRESS_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [1:0]               req_size,
    input  logic                     req_unsigned,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    output logic                     resp_err,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-3:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_din,
    input  logic [DATA_WIDTH-1:0]    mem_dout
);

    dmem_state_t               r_state;
    logic                      r_we;
    logic [1:0]                r_size;
    logic                      r_unsigned;
    logic [1:0]                r_addr_lo;
    logic [15:0]               r_wdata_lo;
    logic                      r_err;
    logic [ADDRESS_WIDTH-3:0]  r_mem_addr;
    logic [DATA_WIDTH-1:0]     r_mem_din;
    logic [DATA_WIDTH-1:0]     r_resp_rdata;

    logic                      w_accept;
    logic                      w_word_store;
    logic [31:0]               w_load_data;
    logic [31:0]               w_merge_data;

    assign w_accept     = req_valid && (r_state == ST_IDLE);
    assign w_word_store = r_we && (r_size == SZ_WORD);

    dmem_lane_unit u_lane (
        .i_rdata      (mem_dout),
        .i_addr_lo    (r_addr_lo),
        .i_size       (r_size),
        .i_unsigned   (r_unsigned),
        .i_wdata      (r_wdata_lo),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    // Request sequencing FSM with its datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_we         <= 1'b0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_addr_lo    <= 2'b00;
            r_wdata_lo   <= 16'h0000;
            r_err        <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_din    <= '0;
            r_resp_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_we       <= req_we;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_addr_lo  <= req_addr[1:0];
                        r_wdata_lo <= req_wdata[15:0];
                        if (is_misaligned(req_size, req_addr[1:0])) begin
                            r_err        <= 1'b1;
                            r_resp_rdata <= '0;
                            r_state      <= ST_DONE;
                        end else begin
                            r_err      <= 1'b0;
                            r_mem_addr <= req_addr[ADDRESS_WIDTH-1:2];
                            // Word store data must be on mem_din during ACCESS.
                            if (req_we && (req_size == SZ_WORD)) begin
                                r_mem_din <= req_wdata;
                            end else begin
                                r_mem_din <= r_mem_din;
                            end
                            // Stores report zero read data.
                            if (req_we) begin
                                r_resp_rdata <= '0;
                            end else begin
                                r_resp_rdata <= r_resp_rdata;
                            end
                            r_state <= ST_ACCESS;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (w_word_store) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (r_we) begin
                        r_mem_din <= w_merge_data;
                        r_state   <= ST_WRITE;
                    end else begin
                        r_resp_rdata <= w_load_data;
                        r_state      <= ST_DONE;
                    end
                end
                ST_WRITE: begin
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from registered state; forced to zero while reset
    // is asserted so an aborted write never reaches the memory.
    always_comb begin
        if (rst_n) begin
            req_ready  = (r_state == ST_IDLE);
            resp_valid = (r_state == ST_DONE);
            resp_err   = (r_state == ST_DONE) && r_err;
            resp_rdata = r_resp_rdata;
            mem_we     = ((r_state == ST_ACCESS) && w_word_store) ||
                         (r_state == ST_WRITE);
            mem_addr   = r_mem_addr;
            mem_din    = r_mem_din;
        end else begin
            req_ready  = 1'b0;
            resp_valid = 1'b0;
            resp_err   = 1'b0;
            resp_rdata = '0;
            mem_we     = 1'b0;
            mem_addr   = '0;
            mem_din    = '0;
        end
    end

endmodule
